// File: rtl/wb_regfile_pkg.sv
// wb_regfile_pkg: shared widths and write-back source encodings
// for the WB stage, pipeline registers and forwarding unit.
package wb_regfile_pkg;

  localparam int DATA_W_DEF      = 32;
  localparam int ADDR_W_DEF      = 5;
  localparam int LINK_OFFSET_DEF = 4;
  localparam int REG_ZERO        = 0;

  typedef enum logic [1:0] {
    WB_SRC_ALU  = 2'b00,
    WB_SRC_MEM  = 2'b01,
    WB_SRC_LINK = 2'b10
  } wb_src_e;

endpackage

// File: rtl/wb_regfile_if.sv
// wb_regfile_if: MEM/WB inputs, ID read ports, forwarding
// and debug signals of the write-back stage.
interface wb_regfile_if #(
  parameter int DATA_W = wb_regfile_pkg::DATA_W_DEF,
  parameter int ADDR_W = wb_regfile_pkg::ADDR_W_DEF
);

  logic [DATA_W-1:0] WB_PC;
  logic [DATA_W-1:0] WB_ALU_Out;
  logic [DATA_W-1:0] WB_Read_Data;
  logic [1:0]        WB_MemtoReg;
  logic [ADDR_W-1:0] WB_Write_Address;
  logic              WB_RegWrite;
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [DATA_W-1:0] wb_data;
  logic              wb_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;

  modport master (
    output WB_PC, WB_ALU_Out, WB_Read_Data,
    output WB_MemtoReg, WB_Write_Address,
    output WB_RegWrite,
    output rs_addr, rt_addr, dbg_addr,
    input  rs_data, rt_data, dbg_data,
    input  wb_data, wb_we
  );

  modport slave (
    input  WB_PC, WB_ALU_Out, WB_Read_Data,
    input  WB_MemtoReg, WB_Write_Address,
    input  WB_RegWrite,
    input  rs_addr, rt_addr, dbg_addr,
    output rs_data, rt_data, dbg_data,
    output wb_data, wb_we
  );

endinterface

// File: rtl/wb_regfile_wb_mux.sv
// wb_mux: write-back source select plus link adder.
// The link value wraps modulo 2**DATA_W.
module wb_mux
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int LINK_OFFSET = LINK_OFFSET_DEF
) (
  input  logic [DATA_W-1:0] pc_i,
  input  logic [DATA_W-1:0] alu_i,
  input  logic [DATA_W-1:0] mem_i,
  input  logic [1:0]        sel_i,
  output logic [DATA_W-1:0] data_o
);

  logic [DATA_W-1:0] link_d;

  assign link_d = pc_i + DATA_W'(LINK_OFFSET);

  // reserved and unknown selects fall back to the ALU result
  always_comb begin
    data_o = alu_i;
    case (sel_i)
      WB_SRC_MEM:  data_o = mem_i;
      WB_SRC_LINK: data_o = link_d;
      default:     data_o = alu_i;
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: write-back stage and 32-entry register file
// with write-first bypass on the two ID read ports.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int LINK_OFFSET = LINK_OFFSET_DEF
) (
  input logic         clk,
  input logic         rst,
  wb_regfile_if.slave bus
);

  localparam int NREGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] mux_d;
  logic [DATA_W-1:0] wb_data_d;
  logic              wb_we_d;
  logic [DATA_W-1:0] rs_d;
  logic [DATA_W-1:0] rt_d;
  logic [DATA_W-1:0] dbg_d;

  wb_mux #(
    .DATA_W      (DATA_W),
    .LINK_OFFSET (LINK_OFFSET)
  ) u_wb_mux (
    .pc_i   (bus.WB_PC),
    .alu_i  (bus.WB_ALU_Out),
    .mem_i  (bus.WB_Read_Data),
    .sel_i  (bus.WB_MemtoReg),
    .data_o (mux_d)
  );

  assign wb_we_d = bus.WB_RegWrite
                && (bus.WB_Write_Address != ZERO_A)
                && !rst;

  assign wb_data_d = rst ? '0 : mux_d;

  // commit; reset wipes every entry immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_we_d) begin
      regs_q[bus.WB_Write_Address] <= wb_data_d;
    end
  end

  // port A: r0 and reset force 0, else bypass, else array
  always_comb begin
    rs_d = regs_q[bus.rs_addr];
    if (wb_we_d && bus.rs_addr == bus.WB_Write_Address) begin
      rs_d = wb_data_d;
    end
    if (rst || bus.rs_addr == ZERO_A) begin
      rs_d = '0;
    end
  end

  // port B: same rule as port A
  always_comb begin
    rt_d = regs_q[bus.rt_addr];
    if (wb_we_d && bus.rt_addr == bus.WB_Write_Address) begin
      rt_d = wb_data_d;
    end
    if (rst || bus.rt_addr == ZERO_A) begin
      rt_d = '0;
    end
  end

  // debug port sees only committed state
  always_comb begin
    dbg_d = rst ? '0 : regs_q[bus.dbg_addr];
  end

  assign bus.rs_data  = rs_d;
  assign bus.rt_data  = rt_d;
  assign bus.dbg_data = dbg_d;
  assign bus.wb_data  = wb_data_d;
  assign bus.wb_we    = wb_we_d;

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back stage plus architectural register file. Sits directly downstream of the MEM/WB pipeline register and consumes its outputs.
- Selects the write-back value (ALU result, load data or link address) and commits it to a 32-entry register file.
- Serves the two ID-stage read ports, with same-cycle write-to-read bypass.
- Exports the selected write-back value for EX-stage forwarding.

Parameters:
DATA_W, 32, register and datapath width
ADDR_W, 5, register index width (2**ADDR_W entries)
LINK_OFFSET, 4, added to WB_PC to form the link value for jal/jalr

Ports:
clk  in  1  clock
rst  in  1  reset
WB_PC  in  DATA_W  PC of the instruction in WB
WB_ALU_Out  in  DATA_W  ALU result from MEM/WB
WB_Read_Data  in  DATA_W  load data from MEM/WB
WB_MemtoReg  in  2  write-back source select
WB_Write_Address  in  ADDR_W  destination register index
WB_RegWrite  in  1  write enable
rs_addr  in  ADDR_W  ID read port A index
rt_addr  in  ADDR_W  ID read port B index
rs_data  out  DATA_W  read port A data
rt_data  out  DATA_W  read port B data
wb_data  out  DATA_W  selected write-back value, for forwarding
wb_we  out  1  effective write strobe (RegWrite and address != 0 and not in reset)
dbg_addr  in  ADDR_W  debug/testbench read index
dbg_data  out  DATA_W  debug read data, no bypass

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk.
  - While rst is high, all 2**ADDR_W registers are cleared to 0 immediately, not at the next edge.
  - Writes are suppressed.
  - rs_data, rt_data, dbg_data, wb_data are 0 and wb_we is 0.
  - Reset asserted mid-write: the write is lost and the register reads 0.
- Source select, combinational, from WB_MemtoReg:
  - 00: WB_ALU_Out
  - 01: WB_Read_Data
  - 10: WB_PC + LINK_OFFSET, modulo 2**DATA_W (wraps; e.g. 0xFFFFFFFC + 4 = 0x00000000)
  - 11: reserved, selects WB_ALU_Out
- Write: on posedge clk, if wb_we, the register at WB_Write_Address takes wb_data.
  - Register 0 is never written; it always reads 0.
  - WB_RegWrite=1 with address 0 gives wb_we=0 and no state change.
- Read, combinational, zero latency. rs_data:
  - 0 if rs_addr == 0;
  - else wb_data if wb_we and rs_addr == WB_Write_Address (write-first bypass: ID sees the value WB commits this same cycle, so no extra stall);
  - else the stored register.
  - rt_data follows the same rule on rt_addr.
- Both ports may read the same index, and may read the index being written; both receive the bypassed value.
- dbg_data returns the stored value only, with no bypass. A write becomes visible on dbg_data one cycle later.
- Write-to-visible latency is 0 cycles on rs/rt (via bypass) and 1 cycle on dbg.
- No X propagation: undriven selects fall to the reserved case. Outputs stay defined for all input values.

Decomposition:
- Shared package holds:
  - MemtoReg encodings: WB_SRC_ALU=2'b00, WB_SRC_MEM=2'b01, WB_SRC_LINK=2'b10
  - REG_ZERO=0
  - DATA_W / ADDR_W defaults, also used by the pipeline registers and the forwarding unit
- One natural sub-module: wb_mux, the combinational source select plus link adder. The register array, write logic and bypass stay in wb_regfile.

Test Plan:
- Reset: preload r5=0x1234 via writes, pulse rst between clock edges -> dbg_data for r5 reads 0 immediately; all 32 regs read 0; wb_we=0 during rst.
- Source select: MemtoReg=00/01/10/11 with ALU_Out=0xA, Read_Data=0xB, PC=0x100, RegWrite=1, addr=3 -> wb_data = 0xA / 0xB / 0x104 / 0xA, and r3 holds each value after the edge.
- Zero register: RegWrite=1, addr=0, ALU_Out=0xDEADBEEF -> wb_we=0; rs_addr=0 reads 0 in the same cycle and after the edge.
- Bypass: write r7=0x55 while rs_addr=rt_addr=7 in the same cycle -> both read 0x55 before the edge; dbg_data for r7 shows the old value until the edge, then 0x55.
- RegWrite=0: addr=9, ALU_Out=0x77, rs_addr=9 with r9 previously 0x11 -> rs_data=0x11 and r9 unchanged after the edge.
- Link wrap: PC=0xFFFFFFFC, MemtoReg=10, addr=31 -> r31=0x00000000.
